// File: rtl/gci_std_display_vram_writer_if.sv
// Command and memory-interface bundle for the VRAM writer.
// The writer uses the master modport; a command source / memory arbiter uses slave.
interface gci_std_display_vram_writer_if #(
  parameter int P_MEM_ADDR_N = 23
);
  logic                    cmd_valid;
  logic                    cmd_ready;
  logic [31:0]             cmd_addr;
  logic [31:0]             cmd_data;
  logic                    if_req;
  logic                    if_ack;
  logic                    if_finish;
  logic                    if_break;
  logic                    if_busy;
  logic                    if_ena;
  logic                    if_rw;
  logic [P_MEM_ADDR_N-1:0] if_addr;
  logic [7:0]              if_r;
  logic [7:0]              if_g;
  logic [7:0]              if_b;
  logic                    busy;

  modport master (
    input  cmd_valid, cmd_addr, cmd_data, if_ack, if_break, if_busy,
    output cmd_ready, if_req, if_finish, if_ena, if_rw, if_addr,
           if_r, if_g, if_b, busy
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_data, if_ack, if_break, if_busy,
    input  cmd_ready, if_req, if_finish, if_ena, if_rw, if_addr,
           if_r, if_g, if_b, busy
  );
endinterface

// File: rtl/gci_std_display_vram_writer.sv
// Turns CLEAR / PIXEL commands into pixel writes on a shared, arbitrated memory
// interface; a revoked grant resumes from the pixel that was not yet written.
module gci_std_display_vram_writer #(
  parameter int P_MEM_ADDR_N = 23,
  parameter int P_AREA_H     = 640,
  parameter int P_AREA_V     = 480
) (
  input logic                           iCLOCK,
  input logic                           inRESET,
  gci_std_display_vram_writer_if.master bus
);

  localparam logic [31:0] LP_AREA       = 32'(P_AREA_H * P_AREA_V);
  localparam logic [31:0] LP_LAST       = LP_AREA - 32'd1;
  localparam logic [31:0] LP_CLEAR_ADDR = 32'h0000_3000;
  localparam logic [31:0] LP_PIXEL_BASE = 32'h0000_3100;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WORK,
    ST_FIN
  } state_t;

  state_t                  state_q, state_d;
  logic [P_MEM_ADDR_N-1:0] cnt_q, cnt_d;
  logic [P_MEM_ADDR_N-1:0] end_q, end_d;
  logic [P_MEM_ADDR_N-1:0] addr_hold_q, addr_hold_d;
  logic [15:0]             colour_q, colour_d;

  logic        cmd_ready;
  logic        if_req;
  logic        if_finish;
  logic        if_ena;
  logic [31:0] cmd_offset;
  logic        is_clear;
  logic        is_pixel;
  logic        unused_cmd_bits;

  // Decode happens at full 32 bits so out-of-range offsets cannot alias after truncation.
  assign cmd_offset      = bus.cmd_addr - LP_PIXEL_BASE;
  assign is_clear        = (bus.cmd_addr == LP_CLEAR_ADDR);
  assign is_pixel        = (bus.cmd_addr >= LP_PIXEL_BASE) && (cmd_offset < LP_AREA);
  assign unused_cmd_bits = ^bus.cmd_data[31:16];

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    state_d     = state_q;
    cnt_d       = cnt_q;
    end_d       = end_q;
    addr_hold_d = addr_hold_q;
    colour_d    = colour_q;
    cmd_ready   = 1'b0;
    if_req      = 1'b0;
    if_finish   = 1'b0;
    if_ena      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (bus.cmd_valid && (is_clear || is_pixel)) begin
          colour_d = bus.cmd_data[15:0];
          state_d  = ST_REQ;
          if (is_clear) begin
            cnt_d = '0;
            end_d = P_MEM_ADDR_N'(LP_LAST);
          end else begin
            cnt_d = P_MEM_ADDR_N'(cmd_offset);
            end_d = P_MEM_ADDR_N'(cmd_offset);
          end
        end
      end

      ST_REQ: begin
        if_req = 1'b1;
        if (bus.if_ack) state_d = ST_WORK;
      end

      ST_WORK: begin
        addr_hold_d = cnt_q;
        // A break wins over busy: the grant is gone, so re-arbitrate and keep the counter.
        if (bus.if_break) begin
          state_d = ST_REQ;
        end else if (!bus.if_busy) begin
          if_ena = 1'b1;
          cnt_d  = cnt_q + P_MEM_ADDR_N'(1);
          if (cnt_q == end_q) state_d = ST_FIN;
        end
      end

      ST_FIN: begin
        if_finish = 1'b1;
        state_d   = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge iCLOCK) begin
    // NOTE: colour and address registers are reset too, because they drive visible outputs.
    if (!inRESET) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      end_q       <= '0;
      addr_hold_q <= '0;
      colour_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      end_q       <= end_d;
      addr_hold_q <= addr_hold_d;
      colour_q    <= colour_d;
    end
  end

  // Ready is forced low while reset is held, and rises on the first cycle after release.
  assign bus.cmd_ready = cmd_ready && inRESET;
  assign bus.if_req    = if_req;
  assign bus.if_finish = if_finish;
  assign bus.if_ena    = if_ena;
  assign bus.if_rw     = 1'b1;
  assign bus.if_addr   = (state_q == ST_WORK) ? cnt_q : addr_hold_q;
  assign bus.if_r      = {colour_q[15:11], colour_q[15:13]};
  assign bus.if_g      = {colour_q[10:5],  colour_q[10:9]};
  assign bus.if_b      = {colour_q[4:0],   colour_q[4:2]};
  assign bus.busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_gci_std_display_vram_writer.sv
// Randomised bench for the VRAM writer: a command-level reference model fills a
// write scoreboard, an arbiter model drives ack/busy/break, a monitor compares.
module tb_gci_std_display_vram_writer;

  localparam int N    = 23;
  localparam int H    = 20;
  localparam int V    = 15;
  localparam int AREA = H * V;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  gci_std_display_vram_writer_if #(.P_MEM_ADDR_N(N)) vif ();

  gci_std_display_vram_writer #(
    .P_MEM_ADDR_N(N),
    .P_AREA_H    (H),
    .P_AREA_V    (V)
  ) dut (
    .iCLOCK (clk),
    .inRESET(rst_n),
    .bus    (vif)
  );

  typedef struct {
    int          addr;
    logic [23:0] rgb;
    bit          last;
  } wr_t;

  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  int  exp_fin  = 0;
  int  fin_seen = 0;
  int  wr_count = 0;

  int  ack_lat     = 0;
  bit  rand_busy   = 1'b0;
  int  stall_cnt   = 0;
  int  brk_at      = -1;
  bit  brk_hit     = 1'b0;
  int  resume_addr = 0;

  bit  chk_fin_next = 1'b0;
  bit  chk_rdy_next = 1'b0;
  bit  chk_req_next = 1'b0;
  bit  chk_resume   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: RGB565 expanded to 8 bits by shifting up and refilling the low bits from the top.
  function automatic logic [23:0] expand(input logic [15:0] c);
    int r5, g6, b5;
    r5 = int'(c) / 2048;
    g6 = (int'(c) / 32) % 64;
    b5 = int'(c) % 32;
    return {8'(r5 * 8 + r5 / 4), 8'(g6 * 4 + g6 / 16), 8'(b5 * 8 + b5 / 4)};
  endfunction

  function automatic void model_cmd(input logic [31:0] a, input logic [31:0] d);
    wr_t w;
    w.rgb = expand(d[15:0]);
    if (a == 32'h3000) begin
      for (int i = 0; i < AREA; i++) begin
        w.addr = i;
        w.last = (i == AREA - 1);
        exp_q.push_back(w);
      end
      exp_fin++;
    end else if (a >= 32'h3100 && (a - 32'h3100) < AREA) begin
      w.addr = int'(a - 32'h3100);
      w.last = 1'b1;
      exp_q.push_back(w);
      exp_fin++;
    end
  endfunction

  // Arbiter / memory model: grants after a set or random number of REQ cycles,
  // injects busy stalls and a one-shot break at a chosen pixel address.
  initial begin
    int req_seen;
    int ack_target;
    req_seen   = 0;
    ack_target = 1;
    vif.if_ack   = 1'b0;
    vif.if_break = 1'b0;
    vif.if_busy  = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      vif.if_ack   = 1'b0;
      vif.if_break = 1'b0;
      vif.if_busy  = 1'b0;
      if (vif.if_req) begin
        if (req_seen == 0) ack_target = (ack_lat > 0) ? ack_lat : int'($urandom_range(1, 3));
        req_seen++;
        if (req_seen >= ack_target) vif.if_ack = 1'b1;
      end else begin
        req_seen = 0;
      end
      if (vif.busy && !vif.if_req && !vif.if_finish) begin
        if (brk_at >= 0 && int'(vif.if_addr) == brk_at) begin
          vif.if_break = 1'b1;
          resume_addr  = brk_at;
          brk_at       = -1;
          brk_hit      = 1'b1;
        end else if (stall_cnt > 0) begin
          vif.if_busy = 1'b1;
          stall_cnt--;
        end else if (rand_busy && $urandom_range(0, 3) == 0) begin
          vif.if_busy = 1'b1;
        end
      end
    end
  end

  // Monitor: pops the scoreboard on every write strobe and checks the protocol around it.
  always @(negedge clk) begin
    wr_t e;
    if (rst_n) begin
      if (chk_req_next) begin
        check("req_after_break", vif.if_req, 1);
        chk_req_next = 1'b0;
      end
      if (chk_fin_next) begin
        check("finish_after_last_write", vif.if_finish, 1);
        chk_fin_next = 1'b0;
      end
      if (chk_rdy_next) begin
        check("ready_after_finish", vif.cmd_ready, 1);
        chk_rdy_next = 1'b0;
      end
      if (vif.if_break) begin
        check("no_write_on_break", vif.if_ena, 0);
        chk_req_next = 1'b1;
        chk_resume   = 1'b1;
      end
      if (vif.if_busy) check("no_write_on_busy", vif.if_ena, 0);
      if (vif.if_ena) begin
        wr_count++;
        check("write_rw", vif.if_rw, 1);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: got addr 0x%0h, expected no write at %0t", vif.if_addr, $time);
        end else begin
          e = exp_q.pop_front();
          check("write_addr", vif.if_addr, e.addr);
          check("write_rgb", {vif.if_r, vif.if_g, vif.if_b}, e.rgb);
          if (e.last) chk_fin_next = 1'b1;
        end
        if (chk_resume) begin
          check("resume_addr", vif.if_addr, resume_addr);
          chk_resume = 1'b0;
        end
      end
      if (vif.if_finish) begin
        fin_seen++;
        chk_rdy_next = 1'b1;
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (!vif.cmd_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("idle_within_budget", vif.cmd_ready, 1);
  endtask

  task automatic send_cmd(input logic [31:0] a, input logic [31:0] d);
    wait_idle();
    vif.cmd_valid = 1'b1;
    vif.cmd_addr  = a;
    vif.cmd_data  = d;
    model_cmd(a, d);
    @(posedge clk);
    #1;
    vif.cmd_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},    vif.if_req, 0);
    check({tag, "_finish"}, vif.if_finish, 0);
    check({tag, "_ena"},    vif.if_ena, 0);
    check({tag, "_busy"},   vif.busy, 0);
    check({tag, "_ready"},  vif.cmd_ready, 0);
    check({tag, "_addr"},   vif.if_addr, 0);
    check({tag, "_rgb"},    {vif.if_r, vif.if_g, vif.if_b}, 0);
    check({tag, "_rw"},     vif.if_rw, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w0;
    int n;
    int kind;
    logic [31:0] a;

    vif.cmd_valid = 1'b0;
    vif.cmd_addr  = '0;
    vif.cmd_data  = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_por", vif.cmd_ready, 1);

    // Single red pixel, grant on the second REQ cycle.
    ack_lat = 2;
    send_cmd(32'h3105, 32'h0000_F800);
    wait_idle();
    check("pixel_finish_count", fin_seen, exp_fin);

    // Full clear in green, immediate grant.
    ack_lat = 1;
    w0 = wr_count;
    send_cmd(32'h3000, 32'h0000_07E0);
    wait_idle();
    check("clear_write_count", wr_count - w0, AREA);

    // Clear interrupted by a revoked grant at pixel 100.
    ack_lat   = 0;
    rand_busy = 1'b1;
    brk_hit   = 1'b0;
    brk_at    = 100;
    w0 = wr_count;
    send_cmd(32'h3000, $urandom);
    wait_idle();
    check("break_taken", brk_hit, 1);
    check("break_clear_write_count", wr_count - w0, AREA);

    // Five busy cycles on a single pixel.
    rand_busy = 1'b0;
    stall_cnt = 5;
    send_cmd(32'h3100 + $urandom_range(0, AREA - 1), $urandom);
    wait_idle();
    check("stall_consumed", stall_cnt, 0);

    // Illegal and boundary addresses.
    send_cmd(32'h2000, $urandom);
    check("illegal_busy", vif.busy, 0);
    check("illegal_ready", vif.cmd_ready, 1);
    @(posedge clk);
    #1;
    check("illegal_no_req", vif.if_req, 0);
    send_cmd(32'h3100 + AREA - 1, $urandom);
    wait_idle();
    send_cmd(32'h3100 + AREA, $urandom);
    check("past_end_busy", vif.busy, 0);
    @(posedge clk);
    #1;
    check("past_end_no_req", vif.if_req, 0);
    check("boundary_finish_count", fin_seen, exp_fin);

    // Reset while a clear is writing pixel 50.
    rand_busy = 1'b1;
    send_cmd(32'h3000, $urandom);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(vif.if_ena && vif.if_addr == 50) && n < 5000);
    check("reached_pixel_50", vif.if_addr, 50);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_reset_outputs("mid_clear");
    exp_q.delete();
    exp_fin--;
    chk_fin_next = 1'b0;
    chk_rdy_next = 1'b0;
    chk_req_next = 1'b0;
    chk_resume   = 1'b0;
    rand_busy    = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_mid_reset", vif.cmd_ready, 1);
    check("no_finish_on_reset", fin_seen, exp_fin);
    send_cmd(32'h3107, 32'h0000_1234);
    wait_idle();

    // Random mix of pixels, illegal addresses, occasional clears and breaks.
    for (int i = 0; i < 40; i++) begin
      rand_busy = $urandom_range(0, 1);
      kind = $urandom_range(0, 9);
      if (kind == 0)      a = 32'h3000;
      else if (kind <= 2) a = $urandom;
      else                a = 32'h3100 + $urandom_range(0, AREA - 1);
      if (kind > 2 && $urandom_range(0, 3) == 0) brk_at = int'(a - 32'h3100);
      send_cmd(a, $urandom);
      wait_idle();
      brk_at = -1;
    end

    wait_idle();
    check("scoreboard_empty", exp_q.size(), 0);
    check("finish_total", fin_seen, exp_fin);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
